ppr_sequencer: RTL and testbench

//  Executes one post-package-repair request granted by the PPR arbiter.

---
 rtl/ppr_sequencer.sv | 173 +++++++++++++++++
 tb/tb_ppr_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ppr_sequencer.sv
// rtl/ppr_sequencer.sv - post-package-repair command sequencer for one pseudo channel request
// Issues PREA, MRS_EN, ACT, WR, PRE, MRS_EX with timing gaps, then reports completion.
module ppr_sequencer #(
   parameter int N_CH      = 32,
   parameter int ADDR_SIZE = 24,
   parameter int T_RP      = 14,
   parameter int T_MRD     = 8,
   parameter int T_RCD     = 14,
   parameter int T_HPPR    = 2000,
   parameter int T_SPPR    = 200,
   localparam int CH_W     = $clog2(N_CH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [1:0]           req_type_i,
   input  logic [ADDR_SIZE-1:0] req_addr_i,
   input  logic [CH_W-1:0]      req_ch_i,
   output logic                 cmd_valid_o,
   input  logic                 cmd_ready_i,
   output logic [2:0]           cmd_o,
   output logic [CH_W-1:0]      cmd_ch_o,
   output logic [ADDR_SIZE-1:0] cmd_addr_o,
   output logic                 done_o,
   output logic [CH_W-1:0]      done_ch_o,
   output logic                 err_o
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAX_GAP = max2(max2(max2(T_RP, T_MRD), max2(T_RCD, T_HPPR)), T_SPPR);
   localparam int TW      = $clog2(MAX_GAP + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_DONE   = 3'd3,
      S_REJECT = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      C_NONE   = 3'd0,
      C_PREA   = 3'd1,
      C_MRS_EN = 3'd2,
      C_ACT    = 3'd3,
      C_WR     = 3'd4,
      C_PRE    = 3'd5,
      C_MRS_EX = 3'd6
   } cmd_t;

   state_t                state_q, state_d;
   cmd_t                  cmd_q, cmd_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  hard_q;
   logic [ADDR_SIZE-1:0]  addr_q;
   logic [CH_W-1:0]       ch_q;
   logic                  latch_en;
   logic                  type_legal;
   logic [TW-1:0]         gap_m1;
   logic                  addr_cmd;

   assign type_legal = (req_type_i == 2'b01) || (req_type_i == 2'b10);

   // Timer reload is gap-1 so the next command rises exactly gap cycles after the handshake.
   always_comb begin
      gap_m1 = '0;
      unique case (cmd_q)
         C_PREA, C_PRE:     gap_m1 = TW'(T_RP - 1);
         C_MRS_EN, C_MRS_EX: gap_m1 = TW'(T_MRD - 1);
         C_ACT:             gap_m1 = TW'(T_RCD - 1);
         C_WR:              gap_m1 = hard_q ? TW'(T_HPPR - 1) : TW'(T_SPPR - 1);
         default:           gap_m1 = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cmd_q   <= C_NONE;
         timer_q <= '0;
         hard_q  <= 1'b0;
         addr_q  <= '0;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         timer_q <= timer_d;
         if (latch_en) begin
            hard_q <= (req_type_i == 2'b01);
            addr_q <= req_addr_i;
            ch_q   <= req_ch_i;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      timer_d     = timer_q;
      latch_en    = 1'b0;
      req_ready_o = 1'b0;
      cmd_valid_o = 1'b0;
      done_o      = 1'b0;
      err_o       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               latch_en = 1'b1;
               if (type_legal) begin
                  state_d = S_ISSUE;
                  cmd_d   = C_PREA;
               end else begin
                  state_d = S_REJECT;
               end
            end
         end
         S_ISSUE: begin
            cmd_valid_o = 1'b1;
            if (cmd_ready_i) begin
               timer_d = gap_m1;
               if (gap_m1 == '0) begin
                  // Gap of one: skip WAIT and present the next command back-to-back.
                  if (cmd_q == C_MRS_EX) begin
                     state_d = S_DONE;
                     cmd_d   = C_NONE;
                  end else begin
                     cmd_d = cmd_t'(cmd_q + 3'd1);
                  end
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            timer_d = timer_q - 1'b1;
            if (timer_q == TW'(1)) begin
               if (cmd_q == C_MRS_EX) begin
                  state_d = S_DONE;
                  cmd_d   = C_NONE;
               end else begin
                  state_d = S_ISSUE;
                  cmd_d   = cmd_t'(cmd_q + 3'd1);
               end
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         S_REJECT: begin
            done_o  = 1'b1;
            err_o   = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cmd_d   = C_NONE;
         end
      endcase
   end

   assign addr_cmd   = (cmd_q == C_ACT) || (cmd_q == C_WR) || (cmd_q == C_PRE);
   assign cmd_o      = cmd_valid_o ? cmd_q : 3'd0;
   assign cmd_ch_o   = ch_q;
   assign cmd_addr_o = (cmd_valid_o && addr_cmd) ? addr_q : '0;
   assign done_ch_o  = done_o ? ch_q : '0;

endmodule

// File: tb/tb_ppr_sequencer.sv
// tb/tb_ppr_sequencer.sv - directed self-checking bench for ppr_sequencer
// Event cycles are counted relative to the request acceptance cycle (cycle 0).
module tb_ppr_sequencer;
   localparam int CH_W = 5;
   localparam int AW   = 24;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [1:0]      req_type = 2'b00;
   logic [AW-1:0]   req_addr = '0;
   logic [CH_W-1:0] req_ch = '0;
   logic            cmd_valid;
   logic            cmd_ready = 1'b1;
   logic [2:0]      cmd;
   logic [CH_W-1:0] cmd_ch;
   logic [AW-1:0]   cmd_addr;
   logic            done;
   logic [CH_W-1:0] done_ch;
   logic            err;

   ppr_sequencer #(
      .N_CH(32), .ADDR_SIZE(AW), .T_RP(3), .T_MRD(2), .T_RCD(3), .T_HPPR(10), .T_SPPR(4)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_type_i(req_type),
      .req_addr_i(req_addr), .req_ch_i(req_ch),
      .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_o(cmd),
      .cmd_ch_o(cmd_ch), .cmd_addr_o(cmd_addr),
      .done_o(done), .done_ch_o(done_ch), .err_o(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int base, r0_ready;
   int hs[8];
   int hs_ch[8];
   int act_addr, exp_addr, act_bad, any_valid;
   int done_at, done_ch_s, err_s, ready_at;
   int bp_lo, bp_hi, rst_at, hold_from, acc2, prea2;
   int pr_valid, pr_done, pr_ready;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      for (int i = 0; i < 8; i++) begin
         hs[i] = -1;
         hs_ch[i] = -1;
      end
      act_addr = -1; act_bad = 0; any_valid = 0;
      done_at = -1; done_ch_s = -1; err_s = -1; ready_at = -1;
      bp_lo = -10; bp_hi = -10; rst_at = -10; hold_from = -10;
      acc2 = -1; prea2 = -1;
      pr_valid = -1; pr_done = -1; pr_ready = -1;
   endtask

   // Entered #1 after a rising edge; observes the cycle at the falling edge.
   task automatic obs_cycle();
      int rel;
      rel = cyc - base;
      cmd_ready = !(rel >= bp_lo && rel <= bp_hi);
      rst = (rel == rst_at);
      if (hold_from >= 0 && rel >= hold_from && acc2 < 0) begin
         req_valid = 1'b1;
         req_type  = 2'b01;
         req_addr  = 24'h0ABCDE;
         req_ch    = 5'd9;
      end else begin
         req_valid = 1'b0;
      end
      @(negedge clk);
      if (cmd_valid && cmd_ready) begin
         if (acc2 >= 0 && cmd == 3'd1) prea2 = rel;
         else begin
            hs[cmd] = rel;
            hs_ch[cmd] = cmd_ch;
            if (cmd == 3'd3) act_addr = cmd_addr;
         end
      end
      if (cmd_valid && cmd == 3'd3 && cmd_addr !== exp_addr[AW-1:0]) act_bad++;
      if (cmd_valid) any_valid = 1;
      if (done) begin
         done_at = rel; done_ch_s = done_ch; err_s = err;
      end
      if (req_ready && done_at >= 0 && ready_at < 0) ready_at = rel;
      if (hold_from >= 0 && req_valid && req_ready && acc2 < 0) acc2 = rel;
      if (rel == rst_at + 1) begin
         pr_valid = cmd_valid; pr_done = done; pr_ready = req_ready;
      end
      @(posedge clk); #1;
   endtask

   task automatic start_req(input logic [1:0] t, input logic [AW-1:0] a,
                            input logic [CH_W-1:0] c, input int n);
      base = cyc;
      exp_addr = a;
      req_valid = 1'b1; req_type = t; req_addr = a; req_ch = c; cmd_ready = 1'b1;
      @(negedge clk);
      r0_ready = req_ready;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) obs_cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = 1'b0; cmd_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic chk_seq(input string tag, input int p1, input int p2, input int p3,
                          input int p4, input int p5, input int p6, input int d, input int r);
      check({tag, "_prea"},   hs[1], p1);
      check({tag, "_mrs_en"}, hs[2], p2);
      check({tag, "_act"},    hs[3], p3);
      check({tag, "_wr"},     hs[4], p4);
      check({tag, "_pre"},    hs[5], p5);
      check({tag, "_mrs_ex"}, hs[6], p6);
      check({tag, "_done"},   done_at, d);
      check({tag, "_ready"},  ready_at, r);
   endtask

   initial begin
      clear_obs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 1);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_cmd", cmd, 0);
      check("rst_cmd_ch", cmd_ch, 0);
      check("rst_cmd_addr", cmd_addr, 0);
      check("rst_done", done, 0);
      check("rst_done_ch", done_ch, 0);
      check("rst_err", err, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // hard PPR, no backpressure
      clear_obs();
      start_req(2'b01, 24'h012345, 5'd5, 27);
      check("t1_accept_ready", r0_ready, 1);
      chk_seq("t1", 1, 4, 6, 9, 19, 22, 24, 25);
      check("t1_act_addr", act_addr, 32'h012345);
      check("t1_cmd_ch", hs_ch[4], 5);
      check("t1_done_ch", done_ch_s, 5);
      check("t1_err", err_s, 0);
      do_reset();

      // backpressure on cycles 6-9 holds ACT
      clear_obs();
      bp_lo = 6; bp_hi = 9;
      start_req(2'b01, 24'h012345, 5'd5, 31);
      chk_seq("t2", 1, 4, 10, 13, 23, 26, 28, 29);
      check("t2_act_stable", act_bad, 0);
      check("t2_act_addr", act_addr, 32'h012345);
      do_reset();

      // illegal type
      clear_obs();
      start_req(2'b11, 24'h00FFFF, 5'd7, 4);
      check("t3_no_cmd", any_valid, 0);
      check("t3_done", done_at, 1);
      check("t3_err", err_s, 1);
      check("t3_done_ch", done_ch_s, 7);
      check("t3_ready", ready_at, 2);
      do_reset();

      // soft PPR
      clear_obs();
      start_req(2'b10, 24'hFEDCBA, 5'd31, 21);
      chk_seq("t4", 1, 4, 6, 9, 13, 16, 18, 19);
      check("t4_act_addr", act_addr, 32'hFEDCBA);
      check("t4_done_ch", done_ch_s, 31);
      check("t4_err", err_s, 0);
      do_reset();

      // reset mid-sequence, then a fresh request
      clear_obs();
      rst_at = 12;
      start_req(2'b01, 24'h012345, 5'd5, 16);
      check("t5_post_valid", pr_valid, 0);
      check("t5_post_done", pr_done, 0);
      check("t5_post_ready", pr_ready, 1);
      check("t5_no_done", done_at, -1);
      clear_obs();
      start_req(2'b01, 24'h012345, 5'd5, 27);
      chk_seq("t5b", 1, 4, 6, 9, 19, 22, 24, 25);
      check("t5b_done_ch", done_ch_s, 5);
      do_reset();

      // second request held while busy
      clear_obs();
      hold_from = 2;
      start_req(2'b01, 24'h012345, 5'd5, 28);
      check("t6_done", done_at, 24);
      check("t6_ready", ready_at, 25);
      check("t6_accept2", acc2, 25);
      check("t6_prea2", prea2, 26);
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
